// File: rtl/ex_sel_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ex_sel_pipe
// Purpose  : Indexed operand select feeding a DEPTH-stage stall/flush pipeline
//            with out-of-range select flagging and a saturating error count.
// Revision : 1.0  initial release
// ============================================================================
module ex_sel_pipe #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4,
    parameter int DEPTH = 1,
    parameter int SELW  = $clog2(NSRC)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [SELW-1:0]         sel,
    input  logic [NSRC*WIDTH-1:0]   src,
    input  logic                    stall,
    input  logic                    flush,
    output logic [WIDTH-1:0]        y,
    output logic                    out_valid,
    output logic                    sel_err,
    output logic [7:0]              err_cnt
);

    localparam logic [7:0] c_CNT_MAX = 8'hFF;

    logic [WIDTH-1:0] w_mux;
    logic             w_hit;
    logic             w_err;
    logic             w_err_inc;

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_err;
    logic [7:0]       r_err_cnt;

    // A select that matches no source leaves w_hit low and the data at zero.
    always_comb begin
        w_mux = '0;
        w_hit = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (sel == SELW'(k)) begin
                w_mux = src[k*WIDTH +: WIDTH];
                w_hit = 1'b1;
            end
        end
    end

    assign w_err     = in_valid & ~w_hit;
    assign w_err_inc = w_err & ~stall & ~flush & (r_err_cnt != c_CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
            r_valid <= '0;
            r_err   <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
            r_valid <= '0;
            r_err   <= '0;
        end else if (!stall) begin
            r_data[0]  <= w_mux;
            r_valid[0] <= in_valid;
            r_err[0]   <= w_err;
            // Data moves regardless of valid so bubbles carry their payload.
            for (int i = 1; i < DEPTH; i++) begin
                r_data[i]  <= r_data[i-1];
                r_valid[i] <= r_valid[i-1];
                r_err[i]   <= r_err[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 8'd0;
        end else if (w_err_inc) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign y         = r_data[DEPTH-1];
    assign out_valid = r_valid[DEPTH-1];
    assign sel_err   = r_err[DEPTH-1];
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ex_sel_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_sel_pipe
// Purpose  : Self-checking bench driving five parameterisations of ex_sel_pipe
//            from shared stimulus against per-instance queue scoreboards.
// Revision : 1.0  initial release
// ============================================================================
module tb_ex_sel_pipe;

    localparam int c_NINST = 5;

    typedef struct packed {
        logic        err;
        logic        vld;
        logic [31:0] data;
    } ent_t;

    function automatic int ns_f(input int g);
        case (g)
            0:       return 4;
            1:       return 5;
            2:       return 3;
            3:       return 2;
            default: return 16;
        endcase
    endfunction

    function automatic int dp_f(input int g);
        case (g)
            0:       return 1;
            1:       return 3;
            2:       return 2;
            3:       return 4;
            default: return 2;
        endcase
    endfunction

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic [3:0]     sel;
    logic [511:0]   src_all;
    logic           stall;
    logic           flush;

    logic [31:0]    ya [c_NINST];
    logic           va [c_NINST];
    logic           ea [c_NINST];
    logic [7:0]     ca [c_NINST];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < c_NINST; g++) begin : g_dut
        localparam int NS = ns_f(g);
        localparam int DP = dp_f(g);
        localparam int SW = $clog2(NS);

        logic [31:0] w_y;
        logic        w_v;
        logic        w_e;
        logic [7:0]  w_c;

        ex_sel_pipe #(.WIDTH(32), .NSRC(NS), .DEPTH(DP)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .sel       (sel[SW-1:0]),
            .src       (src_all[NS*32-1:0]),
            .stall     (stall),
            .flush     (flush),
            .y         (w_y),
            .out_valid (w_v),
            .sel_err   (w_e),
            .err_cnt   (w_c)
        );

        assign ya[g] = w_y;
        assign va[g] = w_v;
        assign ea[g] = w_e;
        assign ca[g] = w_c;

        // Scoreboard: newest operand pushed at the front, the back is what y must show.
        ent_t q [$];
        int   m_cnt;

        initial begin
            m_cnt = 0;
            for (int i = 0; i < DP; i++) q.push_front('0);
        end

        always @(posedge clk or negedge rst_n) begin
            ent_t e;
            int   s;
            if (!rst_n) begin
                q.delete();
                for (int i = 0; i < DP; i++) q.push_front('0);
                m_cnt = 0;
            end else if (flush) begin
                q.delete();
                for (int i = 0; i < DP; i++) q.push_front('0);
            end else if (!stall) begin
                s      = int'(sel) & ((1 << SW) - 1);
                e.data = (s < NS) ? src_all[s*32 +: 32] : 32'h0;
                e.vld  = in_valid;
                e.err  = in_valid && (s >= NS);
                if (e.err && m_cnt < 255) m_cnt = m_cnt + 1;
                q.push_front(e);
                void'(q.pop_back());
            end
        end

        always @(negedge clk) begin
            ent_t x;
            x = q[$];
            checks++;
            assert (w_y === x.data) else begin
                failures++;
                $error("FAIL sb_y[%0d] obs=%h exp=%h", g, w_y, x.data);
            end
            checks++;
            assert (w_v === x.vld) else begin
                failures++;
                $error("FAIL sb_valid[%0d] obs=%b exp=%b", g, w_v, x.vld);
            end
            checks++;
            assert (w_e === x.err) else begin
                failures++;
                $error("FAIL sb_err[%0d] obs=%b exp=%b", g, w_e, x.err);
            end
            checks++;
            assert (w_c === 8'(m_cnt)) else begin
                failures++;
                $error("FAIL sb_cnt[%0d] obs=%0d exp=%0d", g, w_c, m_cnt);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag, input logic with_cnt);
        for (int g = 0; g < c_NINST; g++) begin
            chk($sformatf("%s_y%0d", tag, g), ya[g], 32'h0);
            chk($sformatf("%s_v%0d", tag, g), 32'(va[g]), 32'h0);
            chk($sformatf("%s_e%0d", tag, g), 32'(ea[g]), 32'h0);
            if (with_cnt) chk($sformatf("%s_c%0d", tag, g), 32'(ca[g]), 32'h0);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sel      = 4'd0;
        stall    = 1'b0;
        flush    = 1'b0;
        for (int k = 0; k < 16; k++) src_all[k*32 +: 32] = {8{4'(k + 1)}};

        // Reset state
        repeat (2) @(negedge clk);
        chk_all_zero("rst", 1'b1);
        rst_n = 1'b1;

        // Basic select, DEPTH=1 instance
        sel = 4'd0; in_valid = 1'b1;
        @(negedge clk);
        chk("d1_y0", ya[0], 32'h11111111);
        chk("d1_v0", 32'(va[0]), 32'h1);
        sel = 4'd3;
        @(negedge clk);
        chk("d1_y3", ya[0], 32'h44444444);
        chk("d1_v3", 32'(va[0]), 32'h1);

        // DEPTH=3 latency, then stalled flight
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        sel = 4'd2; in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("lat_v%0d", k), 32'(va[1]), 32'(k == 3));
            if (k == 3) chk("lat_y", ya[1], 32'h33333333);
        end
        repeat (3) @(negedge clk);
        sel = 4'd2; in_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            stall    = (k == 1 || k == 2);
            chk($sformatf("stl_v%0d", k), 32'(va[1]), 32'(k == 5));
            if (k == 5) chk("stl_y", ya[1], 32'h33333333);
        end

        // Flush beats stall; an erroring input on the flush edge is not counted
        sel = 4'd1; in_valid = 1'b1;
        repeat (2) @(negedge clk);
        sel = 4'd3; stall = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk_all_zero("flush", 1'b0);
        chk("flush_cnt", 32'(ca[2]), 32'd1);
        stall = 1'b0; flush = 1'b0; in_valid = 1'b0;

        // Saturating error count on NSRC=3
        sel = 4'd3; in_valid = 1'b1;
        repeat (300) @(negedge clk);
        chk("sat_y", ya[2], 32'h0);
        chk("sat_v", 32'(va[2]), 32'h1);
        chk("sat_e", 32'(ea[2]), 32'h1);
        chk("sat_c", 32'(ca[2]), 32'd255);
        chk("pow2_c0", 32'(ca[0]), 32'd0);
        chk("pow2_c3", 32'(ca[3]), 32'd0);
        chk("pow2_c4", 32'(ca[4]), 32'd0);
        chk("inrng_c1", 32'(ca[1]), 32'd0);
        @(negedge clk);
        chk("sat_hold", 32'(ca[2]), 32'd255);

        // Asynchronous reset with operands in flight
        sel = 4'd0; in_valid = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("arst", 1'b1);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stale_v%0d", k), 32'(va[2]), 32'h0);
        end

        // Random traffic, all instances checked by their scoreboards
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            sel      = 4'($urandom_range(0, 15));
            in_valid = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 19) == 0);
            for (int k = 0; k < 16; k++) src_all[k*32 +: 32] = $urandom();
        end
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
